id_ex_hazard_stage: RTL
=======================

# id_ex_hazard_stage

ID/EX pipeline register of the 5-stage RISC-V core, combined with load-use hazard detection and generation of the 2-bit forwarding selects for the EX-stage operand muxes. It captures decoded fields from ID each cycle, inserts bubbles on load-use hazards and on branch flush, freezes on external hold, and drives `ForwardA`/`ForwardB`. The encoding is 00 = register file, 01 = MEM/WB, 10 = EX/MEM. A saturating counter records stall cycles for performance monitoring.

## Interface
Parameters:
- `CNT_W`, 16, width of stall-cycle counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `ID_valid`  in  1  ID holds a real instruction
- `ID_rs1`, `ID_rs2`, `ID_rd`  in  5 each  decoded register indices
- `ID_RD1`, `ID_RD2`, `ID_Imm`, `ID_PC`  in  32 each  operand data, immediate, PC
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemtoReg`, `ID_ALUSrc`  in  1 each  control bits
- `ID_ALUOp`  in  4  ALU operation
- `EX_MEM_rd`  in  5 / `EX_MEM_RegWrite`  in  1  EX/MEM destination
- `MEM_WB_rd`  in  5 / `MEM_WB_RegWrite`  in  1  MEM/WB destination
- `Flush`  in  1  taken branch/jump resolved in EX
- `Hold`  in  1  global freeze (memory busy)
- `ID_EX_*`  out  same widths as `ID_*` inputs (valid, rs1, rs2, rd, RD1, RD2, Imm, PC, control)  registered stage contents
- `ForwardA`, `ForwardB`  out  2  operand forwarding selects
- `Stall`  out  1  PC and IF/ID write-disable
- `stall_count`  out  `CNT_W`  saturating count of cycles with `Stall`=1

## Operation
- Load-use hazard: `lu` = `ID_EX_valid` & `ID_EX_MemRead` & `ID_EX_RegWrite` & (`ID_EX_rd`≠0) & `ID_valid` & (`ID_EX_rd`==`ID_rs1` | `ID_EX_rd`==`ID_rs2`).
- Register update priority at each clock edge:
  1. `rst`: all registers are cleared.
  2. `Hold`: all registers are held.
  3. `Flush`: a bubble is loaded.
  4. `lu`: a bubble is loaded.
  5. Otherwise: ID fields are loaded.
- Bubble: `valid`, `RegWrite`, `MemRead`, `MemWrite`, `MemtoReg`, `ALUSrc`, and `ALUOp` are all 0. Data and index fields are don't-care; the implementation drives them to 0.
- `Stall` = `Hold` | (`lu` & ~`Flush`). It is combinational. On `Flush`, IF/ID is squashed upstream, so no stall is needed.
- ForwardA:
  - 10 if `EX_MEM_RegWrite` & `EX_MEM_rd`≠0 & `EX_MEM_rd`==`ID_EX_rs1`.
  - Else 01 if `MEM_WB_RegWrite` & `MEM_WB_rd`≠0 & `MEM_WB_rd`==`ID_EX_rs1`.
  - Else 00.
- ForwardB: same rule using `ID_EX_rs2`.
- EX/MEM has priority over MEM/WB, so the newest value wins.
- Forward selects are combinational from registered fields. They are forced to 00 when `ID_EX_valid`=0.
- Register x0 is never forwarded and never triggers a stall.
- `stall_count`: +1 on each edge where `Stall`=1 and `rst`=0. It saturates at all-ones and is cleared by `rst`.
- Same-cycle register-file write/read bypass is handled inside the register file, not in this block.

## Timing
- Latency: 1 cycle from ID inputs to `ID_EX_*`.
- Reset values:
  - every `ID_EX_*` output = 0.
  - `ForwardA` = `ForwardB` = 00.
  - `stall_count` = 0.
  - `Stall` = `Hold` (combinational).
- A load-use stall lasts exactly 1 cycle. Cycle n: `lu`=1, `Stall`=1. Edge: bubble enters ID/EX. Cycle n+1: the load moves to EX/MEM, `lu`=0, and the dependent instruction enters at the next edge with `ForwardA` or `ForwardB` = 01 (load value from MEM/WB).
- `Flush` and `lu` in the same cycle: a bubble is loaded, `Stall`=0.
- `Hold` and `Flush` in the same cycle: `Hold` wins, contents are unchanged, and `Flush` must be re-presented by upstream. `Stall`=1.
- `rst` asserted mid-stall: the next edge clears everything. There is no residual bubble or stall state.
- Consecutive loads with a chained dependence each cost exactly 1 stall cycle.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs. Required: all `ID_EX_*` = 0, `Forward*` = 00, `stall_count` = 0.
- EX/MEM forward: `ID_EX_rs1`=5, `EX_MEM_rd`=5, `EX_MEM_RegWrite`=1, `MEM_WB_rd`=5, `MEM_WB_RegWrite`=1. Required: `ForwardA`=10. Drop `EX_MEM_RegWrite`: `ForwardA`=01. Set rd=0: `ForwardA`=00.
- Load-use: `lw x7` in ID/EX, then `add x8,x7,x1` in ID. Required: `Stall`=1 for exactly 1 cycle; a bubble (`valid`=0) follows the load; the add enters next with `ForwardA`=01; `stall_count`=1.
- Flush during `lu`: `Flush`=1 in the same cycle as the hazard. Required: `Stall`=0 and ID/EX becomes a bubble.
- Hold: 3 cycles of `Hold`=1 with changing ID inputs. Required: `ID_EX_*` unchanged, `Stall`=1, `stall_count` +3.
- Saturation: `CNT_W`=4 with 20 stall cycles. Required: `stall_count` stops at 15.

Source files
------------

// File: rtl/id_ex_hazard_stage_if.sv
// ID/EX stage bus: decoded ID fields, downstream destinations,
// control inputs and the registered stage contents driven back out.
interface id_ex_hazard_stage_if;
    logic        ID_valid;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic [4:0]  ID_rd;
    logic [31:0] ID_RD1;
    logic [31:0] ID_RD2;
    logic [31:0] ID_Imm;
    logic [31:0] ID_PC;
    logic        ID_RegWrite;
    logic        ID_MemRead;
    logic        ID_MemWrite;
    logic        ID_MemtoReg;
    logic        ID_ALUSrc;
    logic [3:0]  ID_ALUOp;

    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_RegWrite;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_RegWrite;
    logic        Flush;
    logic        Hold;

    logic        ID_EX_valid;
    logic [4:0]  ID_EX_rs1;
    logic [4:0]  ID_EX_rs2;
    logic [4:0]  ID_EX_rd;
    logic [31:0] ID_EX_RD1;
    logic [31:0] ID_EX_RD2;
    logic [31:0] ID_EX_Imm;
    logic [31:0] ID_EX_PC;
    logic        ID_EX_RegWrite;
    logic        ID_EX_MemRead;
    logic        ID_EX_MemWrite;
    logic        ID_EX_MemtoReg;
    logic        ID_EX_ALUSrc;
    logic [3:0]  ID_EX_ALUOp;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic        Stall;

    modport master (
        output ID_valid, ID_rs1, ID_rs2, ID_rd,
        output ID_RD1, ID_RD2, ID_Imm, ID_PC,
        output ID_RegWrite, ID_MemRead, ID_MemWrite,
        output ID_MemtoReg, ID_ALUSrc, ID_ALUOp,
        output EX_MEM_rd, EX_MEM_RegWrite,
        output MEM_WB_rd, MEM_WB_RegWrite,
        output Flush, Hold,
        input  ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
        input  ID_EX_RD1, ID_EX_RD2, ID_EX_Imm, ID_EX_PC,
        input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
        input  ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_ALUOp,
        input  ForwardA, ForwardB, Stall
    );

    modport slave (
        input  ID_valid, ID_rs1, ID_rs2, ID_rd,
        input  ID_RD1, ID_RD2, ID_Imm, ID_PC,
        input  ID_RegWrite, ID_MemRead, ID_MemWrite,
        input  ID_MemtoReg, ID_ALUSrc, ID_ALUOp,
        input  EX_MEM_rd, EX_MEM_RegWrite,
        input  MEM_WB_rd, MEM_WB_RegWrite,
        input  Flush, Hold,
        output ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
        output ID_EX_RD1, ID_EX_RD2, ID_EX_Imm, ID_EX_PC,
        output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
        output ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_ALUOp,
        output ForwardA, ForwardB, Stall
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion,
// EX operand forwarding selects and a saturating stall counter.
module id_ex_hazard_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_hazard_stage_if.slave bus,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic [3:0]  alu_op;
    } stage_t;

    stage_t d;
    stage_t q;

    logic       lu;
    logic       stall;
    logic       ex_hit_a;
    logic       wb_hit_a;
    logic       ex_hit_b;
    logic       wb_hit_b;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    always_comb begin
        d            = '0;
        d.valid      = bus.ID_valid;
        d.rs1        = bus.ID_rs1;
        d.rs2        = bus.ID_rs2;
        d.rd         = bus.ID_rd;
        d.rd1        = bus.ID_RD1;
        d.rd2        = bus.ID_RD2;
        d.imm        = bus.ID_Imm;
        d.pc         = bus.ID_PC;
        d.reg_write  = bus.ID_RegWrite;
        d.mem_read   = bus.ID_MemRead;
        d.mem_write  = bus.ID_MemWrite;
        d.mem_to_reg = bus.ID_MemtoReg;
        d.alu_src    = bus.ID_ALUSrc;
        d.alu_op     = bus.ID_ALUOp;
    end

    // A load in ID/EX whose result the instruction in ID needs.
    assign lu = q.valid && q.mem_read && q.reg_write
             && (q.rd != 5'd0) && bus.ID_valid
             && ((q.rd == bus.ID_rs1) || (q.rd == bus.ID_rs2));

    assign stall = bus.Hold || (lu && !bus.Flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (!bus.Hold) begin
            if (bus.Flush || lu) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign ex_hit_a = q.valid && bus.EX_MEM_RegWrite
                   && (bus.EX_MEM_rd != 5'd0)
                   && (bus.EX_MEM_rd == q.rs1);
    assign wb_hit_a = q.valid && !ex_hit_a
                   && bus.MEM_WB_RegWrite
                   && (bus.MEM_WB_rd != 5'd0)
                   && (bus.MEM_WB_rd == q.rs1);
    assign ex_hit_b = q.valid && bus.EX_MEM_RegWrite
                   && (bus.EX_MEM_rd != 5'd0)
                   && (bus.EX_MEM_rd == q.rs2);
    assign wb_hit_b = q.valid && !ex_hit_b
                   && bus.MEM_WB_RegWrite
                   && (bus.MEM_WB_rd != 5'd0)
                   && (bus.MEM_WB_rd == q.rs2);

    always_comb begin
        fwd_a = 2'b00;
        unique case (1'b1)
            ex_hit_a: fwd_a = 2'b10;
            wb_hit_a: fwd_a = 2'b01;
            default:  fwd_a = 2'b00;
        endcase
    end

    always_comb begin
        fwd_b = 2'b00;
        unique case (1'b1)
            ex_hit_b: fwd_b = 2'b10;
            wb_hit_b: fwd_b = 2'b01;
            default:  fwd_b = 2'b00;
        endcase
    end

    assign bus.ID_EX_valid    = q.valid;
    assign bus.ID_EX_rs1      = q.rs1;
    assign bus.ID_EX_rs2      = q.rs2;
    assign bus.ID_EX_rd       = q.rd;
    assign bus.ID_EX_RD1      = q.rd1;
    assign bus.ID_EX_RD2      = q.rd2;
    assign bus.ID_EX_Imm      = q.imm;
    assign bus.ID_EX_PC       = q.pc;
    assign bus.ID_EX_RegWrite = q.reg_write;
    assign bus.ID_EX_MemRead  = q.mem_read;
    assign bus.ID_EX_MemWrite = q.mem_write;
    assign bus.ID_EX_MemtoReg = q.mem_to_reg;
    assign bus.ID_EX_ALUSrc   = q.alu_src;
    assign bus.ID_EX_ALUOp    = q.alu_op;
    assign bus.ForwardA       = fwd_a;
    assign bus.ForwardB       = fwd_b;
    assign bus.Stall          = stall;

endmodule
